// File: rtl/kypd_scanner.sv
// rtl/kypd_scanner.sv - 4x4 matrix keypad scanner with debounce and valid/ack key handshake
// Optional feature macro: KYPD_ACCUM_EN builds a 16-bit hex shift-in accumulator on VALUE;
// without it VALUE is tied to zero and no accumulator registers exist.

module kypd_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  ROWS,
  output logic [3:0]  COLS,
  output logic [3:0]  KEY_CODE,
  output logic        KEY_VALID,
  input  logic        KEY_ACK,
  output logic        KEY_DOWN,
  output logic        OVERRUN,
  output logic [15:0] VALUE
);

  localparam int             DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     DEB_N    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2
  } state_t;

  // Key code for a pressed position, position index = column*4 + row.
  function automatic logic [3:0] key_map(input logic [3:0] pos);
    logic [3:0] k;
    case (pos)
      4'd0:  k = 4'h1;
      4'd1:  k = 4'h4;
      4'd2:  k = 4'h7;
      4'd3:  k = 4'h0;
      4'd4:  k = 4'h2;
      4'd5:  k = 4'h5;
      4'd6:  k = 4'h8;
      4'd7:  k = 4'hF;
      4'd8:  k = 4'h3;
      4'd9:  k = 4'h6;
      4'd10: k = 4'h9;
      4'd11: k = 4'hE;
      4'd12: k = 4'hA;
      4'd13: k = 4'hB;
      4'd14: k = 4'hC;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  logic [3:0]    rows_meta;
  logic [3:0]    rows_sync;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic          col_last;
  logic          scan_end;
  logic [11:0]   samp;
  logic [15:0]   hits;
  logic [1:0]    hit_n;
  logic [3:0]    hit_pos;
  logic          cls_none;
  logic          cls_single;
  logic [3:0]    cur_code;
  state_t        state;
  logic [3:0]    cand;
  logic [3:0]    deb_cnt;
  logic [3:0]    rel_cnt;
  logic          accept_now;

  // Two-flop synchroniser for the asynchronous, pulled-up row lines.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rows_meta <= 4'hF;
      rows_sync <= 4'hF;
    end else begin
      rows_meta <= ROWS;
      rows_sync <= rows_meta;
    end
  end

  assign col_last = (div_cnt == DIV_LAST);
  assign scan_end = col_last && (col_idx == 2'd3);

  // Column timer: each column is strobed low for SCAN_DIV cycles, then the strobe rotates.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
      COLS    <= 4'b1110;
    end else if (col_last) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
      COLS    <= {COLS[2:0], COLS[3]};
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Latch pressed-row bits of columns 0..2; column 3 is used live at scan end.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp <= '0;
    end else if (col_last) begin
      case (col_idx)
        2'd0:    samp[3:0]  <= ~rows_sync;
        2'd1:    samp[7:4]  <= ~rows_sync;
        2'd2:    samp[11:8] <= ~rows_sync;
        default: samp       <= samp;
      endcase
    end
  end

  assign hits = {~rows_sync, samp};

  // Classify the full scan: count pressed positions (saturating at 2) and remember one position.
  always_comb begin
    hit_n   = 2'd0;
    hit_pos = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (hits[i]) begin
        if (hit_n != 2'd2) hit_n = hit_n + 2'd1;
        hit_pos = 4'(i);
      end
    end
  end

  assign cls_none   = (hit_n == 2'd0);
  assign cls_single = (hit_n == 2'd1);
  assign cur_code   = key_map(hit_pos);

  // Acceptance happens on the scan end that completes press debounce.
  always_comb begin
    accept_now = 1'b0;
    if (scan_end && cls_single) begin
      case (state)
        S_IDLE:     accept_now = (DEB_N == 4'd1);
        S_DEBOUNCE: accept_now = (cur_code == cand) && ((deb_cnt + 4'd1) == DEB_N);
        default:    accept_now = 1'b0;
      endcase
    end
  end

  // Debounce FSM plus the registered key handshake outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      cand      <= 4'd0;
      deb_cnt   <= 4'd0;
      rel_cnt   <= 4'd0;
      KEY_CODE  <= 4'd0;
      KEY_VALID <= 1'b0;
      KEY_DOWN  <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (scan_end) begin
        case (state)
          S_IDLE: begin
            if (cls_single) begin
              cand <= cur_code;
              if (accept_now) begin
                state   <= S_PRESSED;
                rel_cnt <= 4'd0;
              end else begin
                state   <= S_DEBOUNCE;
                deb_cnt <= 4'd1;
              end
            end
          end
          S_DEBOUNCE: begin
            if (cls_single && cur_code == cand) begin
              if (accept_now) begin
                state   <= S_PRESSED;
                deb_cnt <= 4'd0;
                rel_cnt <= 4'd0;
              end else begin
                deb_cnt <= deb_cnt + 4'd1;
              end
            end else begin
              state   <= S_IDLE;
              deb_cnt <= 4'd0;
            end
          end
          S_PRESSED: begin
            // Only a completely empty scan counts towards release; anything else restarts it.
            if (cls_none) begin
              if ((rel_cnt + 4'd1) == DEB_N) begin
                state    <= S_IDLE;
                rel_cnt  <= 4'd0;
                KEY_DOWN <= 1'b0;
              end else begin
                rel_cnt <= rel_cnt + 4'd1;
              end
            end else begin
              rel_cnt <= 4'd0;
            end
          end
          default: begin
            state   <= S_IDLE;
            deb_cnt <= 4'd0;
            rel_cnt <= 4'd0;
          end
        endcase
      end

      // A new key beats a coincident ack; overrun only latches when the old key was never acked.
      if (accept_now) begin
        KEY_CODE  <= cur_code;
        KEY_VALID <= 1'b1;
        KEY_DOWN  <= 1'b1;
        OVERRUN   <= !KEY_ACK && (OVERRUN || KEY_VALID);
      end else if (KEY_ACK) begin
        KEY_VALID <= 1'b0;
        OVERRUN   <= 1'b0;
      end
    end
  end

`ifdef KYPD_ACCUM_EN
  logic [15:0] accum;

  // Shift each accepted digit into the low nibble; cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      accum <= 16'h0000;
    end else if (accept_now) begin
      accum <= {accum[11:0], cur_code};
    end
  end

  assign VALUE = accum;
`else
  assign VALUE = 16'h0000;
`endif

endmodule

// File: tb/tb_kypd_scanner.sv
// tb/tb_kypd_scanner.sv - self-checking bench for kypd_scanner with a keypad matrix model

module tb_kypd_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        key_down;
  logic        overrun;
  logic [15:0] value;

  logic [15:0] pressed = 16'h0000;
  int          checks = 0;
  int          errors = 0;
  int          accept_cnt = 0;
  logic [3:0]  exp_q[$];

  kypd_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .CLK      (clk),
    .RST      (rst),
    .ROWS     (rows),
    .COLS     (cols),
    .KEY_CODE (key_code),
    .KEY_VALID(key_valid),
    .KEY_ACK  (key_ack),
    .KEY_DOWN (key_down),
    .OVERRUN  (overrun),
    .VALUE    (value)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a held key pulls its row low while its column is strobed.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !cols[c]) rows[r] = 1'b0;
  end

  always @(posedge key_down) accept_cnt++;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    pressed = 16'h0000;
    key_ack = 1'b0;
    cycles(3);
    rst = 1'b0;
  endtask

  task automatic pulse_ack;
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic wait_accept(input int budget, output bit ok);
    int base;
    base = accept_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (accept_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_release(input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (!key_down) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    int w;
    logic [3:0] exp;
    logic [3:0] exp_cols;
    pressed[6] = 1'b1;
    exp_q.push_back(4'h8);
    wait_accept(80, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pre_reset_accept: no acceptance, required one"); end
    exp = exp_q.pop_front();
    checks++;
    if (key_code !== exp) begin errors++; $display("FAIL pre_reset_code: got %h required %h", key_code, exp); end
    cycles(5);
    rst = 1'b1;
    #1;
    checks++;
    if (cols !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_down !== 1'b0 ||
        overrun !== 1'b0 || value !== 16'h0000)
    begin
      errors++;
      $display("FAIL reset_values: cols=%b code=%h valid=%b down=%b ovr=%b value=%h required 1110 0 0 0 0 0000",
               cols, key_code, key_valid, key_down, overrun, value);
    end
    cycles(3);
    rst = 1'b0;
    exp_q.push_back(4'h8);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      exp_cols = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (cols !== exp_cols) begin
        errors++;
        $display("FAIL col_seq k=%0d: got %b required %b", k, cols, exp_cols);
      end
      if (k == 31) begin
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL reaccept_early: valid=%b required 0", key_valid); end
      end
    end
    checks++;
    if (key_valid !== 1'b1 || key_down !== 1'b1) begin
      errors++;
      $display("FAIL reaccept_latency: valid=%b down=%b required 1 1", key_valid, key_down);
    end
    exp = exp_q.pop_front();
    checks++;
    if (key_code !== exp) begin errors++; $display("FAIL reaccept_code: got %h required %h", key_code, exp); end
    pulse_ack();
    pressed = 16'h0000;
    wait_release(80, w);
    cycles(16);
  endtask

  task automatic test_single;
    bit ok;
    int w;
    bit seen;
    logic [3:0] exp;
    pressed[6] = 1'b1;
    exp_q.push_back(4'h8);
    wait_accept(70, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept: no acceptance within 70 cycles"); end
    exp = exp_q.pop_front();
    checks++;
    if (key_code !== exp || key_valid !== 1'b1 || key_down !== 1'b1) begin
      errors++;
      $display("FAIL single_state: code=%h valid=%b down=%b required %h 1 1", key_code, key_valid, key_down, exp);
    end
    pulse_ack();
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL single_ack: valid=%b required 0", key_valid); end
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL single_no_repeat: valid reasserted while held, required 0"); end
    pressed = 16'h0000;
    wait_release(80, w);
    checks++;
    if (w < 16 || w > 56) begin errors++; $display("FAIL single_release: down fell after %0d cycles, required 16..56", w); end
    cycles(16);
  endtask

  task automatic test_bounce;
    int base;
    bit seen;
    base = accept_cnt;
    seen = 1'b0;
    pressed[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    pressed = 16'h0000;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    checks++;
    if (seen || accept_cnt != base) begin
      errors++;
      $display("FAIL bounce: valid_seen=%b accepts=%0d required 0 0", seen, accept_cnt - base);
    end
  endtask

  task automatic test_multi;
    int base;
    bit seen;
    base = accept_cnt;
    seen = 1'b0;
    pressed[1] = 1'b1;
    pressed[9] = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (key_down) seen = 1'b1;
    end
    pressed = 16'h0000;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (key_down) seen = 1'b1;
    end
    checks++;
    if (seen || accept_cnt != base) begin
      errors++;
      $display("FAIL multi: down_seen=%b accepts=%0d required 0 0", seen, accept_cnt - base);
    end
  endtask

  task automatic test_overrun;
    bit ok;
    int w;
    int base;
    logic [3:0] exp;
    pressed[5] = 1'b1;
    exp_q.push_back(4'h5);
    wait_accept(80, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || key_code !== exp) begin errors++; $display("FAIL ovr_first: ok=%b code=%h required 1 %h", ok, key_code, exp); end
    pressed = 16'h0000;
    wait_release(80, w);
    pressed[12] = 1'b1;
    exp_q.push_back(4'hA);
    wait_accept(80, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || key_code !== exp || key_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_second: ok=%b code=%h valid=%b ovr=%b required 1 %h 1 1", ok, key_code, key_valid, overrun, exp);
    end
    pulse_ack();
    checks++;
    if (key_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_ack: valid=%b ovr=%b required 0 0", key_valid, overrun);
    end
    pressed = 16'h0000;
    wait_release(80, w);
    cycles(16);
    // Collision: ack lands exactly on the acceptance edge of the second key.
    pressed[5] = 1'b1;
    exp_q.push_back(4'h5);
    wait_accept(80, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || key_code !== exp) begin errors++; $display("FAIL coll_first: ok=%b code=%h required 1 %h", ok, key_code, exp); end
    pressed = 16'h0000;
    wait_release(80, w);
    cycles(16);
    for (int i = 0; i < 20 && cols !== 4'b0111; i++) @(negedge clk);
    for (int i = 0; i < 20 && cols !== 4'b1110; i++) @(negedge clk);
    base = accept_cnt;
    pressed[12] = 1'b1;
    exp_q.push_back(4'hA);
    cycles(31);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (accept_cnt == base || key_valid !== 1'b1 || key_code !== exp || overrun !== 1'b0) begin
      errors++;
      $display("FAIL coll_second: accepted=%0d valid=%b code=%h ovr=%b required 1 1 %h 0",
               accept_cnt - base, key_valid, key_code, overrun, exp);
    end
    pulse_ack();
    pressed = 16'h0000;
    wait_release(80, w);
    cycles(16);
  endtask

  task automatic test_accum;
    bit ok;
    int w;
    logic [3:0] exp;
    logic [15:0] exp_val;
    int pos_tab[5] = '{0, 4, 8, 1, 5};
    logic [3:0] code_tab[5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    do_reset();
    for (int n = 0; n < 5; n++) begin
      pressed[pos_tab[n]] = 1'b1;
      exp_q.push_back(code_tab[n]);
      wait_accept(80, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || key_code !== exp) begin
        errors++;
        $display("FAIL accum_key%0d: ok=%b code=%h required 1 %h", n, ok, key_code, exp);
      end
      pulse_ack();
      pressed = 16'h0000;
      wait_release(80, w);
      if (n == 3) begin
`ifdef KYPD_ACCUM_EN
        exp_val = 16'h1234;
`else
        exp_val = 16'h0000;
`endif
        checks++;
        if (value !== exp_val) begin errors++; $display("FAIL accum_4: value=%h required %h", value, exp_val); end
      end
    end
`ifdef KYPD_ACCUM_EN
    exp_val = 16'h2345;
`else
    exp_val = 16'h0000;
`endif
    checks++;
    if (value !== exp_val) begin errors++; $display("FAIL accum_5: value=%h required %h", value, exp_val); end
  endtask

  initial begin
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    test_reset();
    test_single();
    test_bounce();
    test_multi();
    test_overrun();
    test_accum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
